// File: rtl/gift_inv_key_sched.sv
// ============================================================================
// gift_inv_key_sched
// ----------------------------------------------------------------------------
// Decryption-side GIFT-128 key schedule.
//
// A master key is loaded on start. The key state is then wound forward to the
// last round, one forward key update per cycle. After that the round keys and
// round constants are streamed out in reverse order, from round NUM_ROUNDS
// down to round 1, over a valid/ready handshake. Each accepted key steps the
// state backward with the inverse key update and the inverse constant LFSR,
// so no per-round key storage is needed.
//
// Parameters
//   NUM_ROUNDS     number of cipher rounds, legal range 2..63 (default 40)
//
// Ports
//   inClk          clock, rising edge
//   inRstN         synchronous active-low reset
//   inStart        load request, accepted only while outBusy = 0
//   inKey[127:0]   master key k7||...||k0 (16-bit words), sampled on accept
//   inReady        consumer accepts the current round key
//   outValid       round key / constant / index are valid
//   outRoundKey    U||V with U = k5||k4 in [63:32], V = k1||k0 in [31:0]
//   outRoundConst  round constant c5..c0 of outRoundIdx
//   outRoundIdx    1-based round number of the current output
//   outBusy        high from start acceptance until the final handshake
//   outDone        one-cycle pulse after the round-1 handshake
//   outErr         (only with GIFT_INV_KS_SELFCHECK_EN) rewind mismatch flag
//
// Optional feature macro: GIFT_INV_KS_SELFCHECK_EN
//   When defined, a copy of the master key is kept and compared with the
//   rewound key state (and the constant with 6'h01) on the final handshake.
//   The result appears on outErr in the same cycle as outDone and is held
//   until the next start acceptance or reset.
// ============================================================================
module gift_inv_key_sched #(
    parameter int NUM_ROUNDS = 40
) (
    input  logic         inClk,
    input  logic         inRstN,
    input  logic         inStart,
    input  logic [127:0] inKey,
    input  logic         inReady,
    output logic         outValid,
    output logic [63:0]  outRoundKey,
    output logic [5:0]   outRoundConst,
    output logic [5:0]   outRoundIdx,
    output logic         outBusy,
    output logic         outDone
`ifdef GIFT_INV_KS_SELFCHECK_EN
    ,
    output logic         outErr
`endif
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WIND = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;

    localparam logic [5:0] LAST_IDX  = 6'(NUM_ROUNDS);
    localparam logic [5:0] FIRST_IDX = 6'd1;
    localparam logic [5:0] INIT_CONST = 6'h01;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]   state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [5:0]   const_q, const_d;
    logic [5:0]   idx_q, idx_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

`ifdef GIFT_INV_KS_SELFCHECK_EN
    logic [127:0] ref_key_q, ref_key_d;
    logic         err_q, err_d;
`endif

    logic         start_accept;
    logic         handshake;

    // ------------------------------------------------------------------------
    // Key / constant update functions
    // ------------------------------------------------------------------------

    // Forward key update: the two low words are rotated right (k1 by 2,
    // k0 by 12) and moved to the top, everything else shifts down two words.
    function automatic logic [127:0] key_fwd(input logic [127:0] k);
        logic [15:0] k1;
        logic [15:0] k0;
        k1 = k[31:16];
        k0 = k[15:0];
        return {k1[1:0], k1[15:2], k0[11:0], k0[15:12], k[127:32]};
    endfunction

    // Inverse key update: undo the forward step. The two top words return to
    // the bottom with the opposite rotations (left by 2 and left by 12).
    function automatic logic [127:0] key_inv(input logic [127:0] n);
        logic [15:0] n7;
        logic [15:0] n6;
        n7 = n[127:112];
        n6 = n[111:96];
        return {n[95:0], n7[13:0], n7[15:14], n6[3:0], n6[15:4]};
    endfunction

    // Forward round-constant LFSR.
    function automatic logic [5:0] const_fwd(input logic [5:0] c);
        return {c[4:0], c[5] ^ c[4] ^ 1'b1};
    endfunction

    // Inverse round-constant LFSR: recovers the old c5 from the feedback bit.
    function automatic logic [5:0] const_inv(input logic [5:0] c);
        return {c[0] ^ c[5] ^ 1'b1, c[5:1]};
    endfunction

    // ------------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------------

    // A start is only honoured from IDLE; busy is low exactly there, so a
    // start coinciding with the final handshake (still in EMIT) is dropped.
    assign start_accept = (state_q == ST_IDLE) && inStart && !busy_q;
    assign handshake    = (state_q == ST_EMIT) && valid_q && inReady;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------

    // Everything holds by default; done is a single-cycle pulse so it falls
    // back to zero unless the final handshake happens this cycle. Winding
    // checks idx before stepping, which yields the first valid output exactly
    // NUM_ROUNDS cycles after the accept edge.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        const_d = const_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_accept) begin
                    key_d   = inKey;
                    const_d = INIT_CONST;
                    idx_d   = FIRST_IDX;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    state_d = ST_WIND;
                end
            end

            ST_WIND: begin
                if (idx_q < LAST_IDX) begin
                    key_d   = key_fwd(key_q);
                    const_d = const_fwd(const_q);
                    idx_d   = idx_q + 6'd1;
                end else begin
                    valid_d = 1'b1;
                    state_d = ST_EMIT;
                end
            end

            ST_EMIT: begin
                if (handshake) begin
                    if (idx_q == FIRST_IDX) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        key_d   = key_inv(key_q);
                        const_d = const_inv(const_q);
                        idx_d   = idx_q - 6'd1;
                    end
                end
            end

            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef GIFT_INV_KS_SELFCHECK_EN
    // The copy of the master key is taken on accept; on the final handshake
    // the fully rewound state must reproduce it and the constant must be back
    // at its initial value. The flag is cleared by the next accepted start.
    always_comb begin
        ref_key_d = ref_key_q;
        err_d     = err_q;
        if (start_accept) begin
            ref_key_d = inKey;
            err_d     = 1'b0;
        end else if (handshake && (idx_q == FIRST_IDX)) begin
            err_d = (key_q != ref_key_q) || (const_q != INIT_CONST);
        end
    end
`endif

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------

    // Synchronous active-low reset clears the whole datapath so the outputs
    // read zero and any operation in progress is abandoned.
    always_ff @(posedge inClk) begin
        if (!inRstN) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            const_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            const_q <= const_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef GIFT_INV_KS_SELFCHECK_EN
    always_ff @(posedge inClk) begin
        if (!inRstN) begin
            ref_key_q <= '0;
            err_q     <= 1'b0;
        end else begin
            ref_key_q <= ref_key_d;
            err_q     <= err_d;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------

    // Outputs come straight from the registers: the current round key is the
    // U (k5||k4) and V (k1||k0) words of the key state.
    assign outValid      = valid_q;
    assign outRoundKey   = {key_q[95:64], key_q[31:0]};
    assign outRoundConst = const_q;
    assign outRoundIdx   = idx_q;
    assign outBusy       = busy_q;
    assign outDone       = done_q;

`ifdef GIFT_INV_KS_SELFCHECK_EN
    assign outErr = err_q;
`endif

endmodule

// File: tb/tb_gift_inv_key_sched.sv
// ============================================================================
// tb_gift_inv_key_sched
// ----------------------------------------------------------------------------
// Directed testbench for gift_inv_key_sched (NUM_ROUNDS = 40). Round keys are
// predicted by stepping the forward GIFT-128 key schedule from the master key;
// round constants come from a hand-derived table.
// ============================================================================
module tb_gift_inv_key_sched;

    localparam int NR = 40;

    logic         inClk;
    logic         inRstN;
    logic         inStart;
    logic [127:0] inKey;
    logic         inReady;
    logic         outValid;
    logic [63:0]  outRoundKey;
    logic [5:0]   outRoundConst;
    logic [5:0]   outRoundIdx;
    logic         outBusy;
    logic         outDone;
`ifdef GIFT_INV_KS_SELFCHECK_EN
    logic         outErr;
`endif

    gift_inv_key_sched #(.NUM_ROUNDS(NR)) dut (
        .inClk        (inClk),
        .inRstN       (inRstN),
        .inStart      (inStart),
        .inKey        (inKey),
        .inReady      (inReady),
        .outValid     (outValid),
        .outRoundKey  (outRoundKey),
        .outRoundConst(outRoundConst),
        .outRoundIdx  (outRoundIdx),
        .outBusy      (outBusy),
        .outDone      (outDone)
`ifdef GIFT_INV_KS_SELFCHECK_EN
        ,
        .outErr       (outErr)
`endif
    );

    initial inClk = 1'b0;
    always #5 inClk = ~inClk;

    int errors = 0;
    int checks = 0;

    // Round constants for rounds 1..40
    logic [5:0] exp_const [1:NR] = '{
        6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
        6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
        6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
        6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A
    };

    logic [63:0] model_rk [1:NR];

    logic [63:0] got_key   [0:63];
    logic [5:0]  got_const [0:63];
    logic [5:0]  got_idx   [0:63];
    int          n_hs;
    int          n_done;
    int          n_unstable;
    bit          timed_out;
    logic        err_at_done;

    localparam logic [127:0] GOLD_KEY = 128'h000102030405060708090A0B0C0D0E0F;

    // Forward GIFT-128 key update
    function automatic logic [127:0] fwd(input logic [127:0] k);
        logic [15:0] k1;
        logic [15:0] k0;
        k1 = k[31:16];
        k0 = k[15:0];
        return {k1[1:0], k1[15:2], k0[11:0], k0[15:12], k[127:32]};
    endfunction

    task automatic build_model(input logic [127:0] k);
        logic [127:0] s;
        s = k;
        for (int r = 1; r <= NR; r++) begin
            model_rk[r] = {s[95:64], s[31:0]};
            s = fwd(s);
        end
    endtask

    task automatic do_reset();
        inRstN  = 1'b0;
        inStart = 1'b0;
        inReady = 1'b0;
        repeat (2) @(negedge inClk);
        inRstN = 1'b1;
        @(negedge inClk);
    endtask

    // Issue a start and wait (bounded) for the first valid output.
    task automatic start_op(input logic [127:0] k, input bit poke, output int cyc);
        inStart = 1'b1;
        inKey   = k;
        @(negedge inClk);
        inStart = 1'b0;
        cyc = 0;
        while (outValid !== 1'b1 && cyc < 200) begin
            inStart = poke && (cyc == 5 || cyc == 20);
            if (inStart) inKey = ~k;
            @(negedge inClk);
            cyc++;
        end
        inStart = 1'b0;
    endtask

    // Drain the key stream with the given ready probability, recording every
    // accepted output and watching for instability while stalled.
    task automatic collect(input int ready_pct, input bit poke);
        bit          stall_prev;
        logic [63:0] pk;
        logic [5:0]  pc;
        logic [5:0]  pi;
        int          budget;
        stall_prev  = 1'b0;
        pk = '0; pc = '0; pi = '0;
        budget      = 0;
        n_hs        = 0;
        n_done      = 0;
        n_unstable  = 0;
        timed_out   = 1'b0;
        err_at_done = 1'bx;
        while (1) begin
            if (outDone === 1'b1) begin
                n_done++;
`ifdef GIFT_INV_KS_SELFCHECK_EN
                err_at_done = outErr;
`endif
            end
            if (stall_prev && (outValid !== 1'b1 || outRoundKey !== pk ||
                               outRoundConst !== pc || outRoundIdx !== pi))
                n_unstable++;
            if (n_hs > 0 && outBusy === 1'b0) break;
            if (budget >= 4000) begin
                timed_out = 1'b1;
                break;
            end
            inReady = ($urandom_range(0, 99) < ready_pct);
            inStart = poke && ($urandom_range(0, 3) == 0);
            if (inStart) inKey = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (outValid === 1'b1 && inReady) begin
                if (n_hs < 64) begin
                    got_key[n_hs]   = outRoundKey;
                    got_const[n_hs] = outRoundConst;
                    got_idx[n_hs]   = outRoundIdx;
                end
                n_hs++;
                if (poke && outRoundIdx == 6'd1) inStart = 1'b1;
            end
            stall_prev = (outValid === 1'b1) && !inReady;
            pk = outRoundKey;
            pc = outRoundConst;
            pi = outRoundIdx;
            @(negedge inClk);
            budget++;
        end
        inStart = 1'b0;
        inReady = 1'b0;
    endtask

    // Compare a collected stream against the model and constant table.
    task automatic compare_stream(input string tag);
        checks++;
        if (n_hs !== NR) begin
            errors++;
            $display("[TB] FAIL %s count: got %0d required %0d", tag, n_hs, NR);
        end
        for (int j = 0; j < NR; j++) begin
            checks++;
            if (got_key[j] !== model_rk[NR - j] || got_const[j] !== exp_const[NR - j] ||
                got_idx[j] !== 6'(NR - j)) begin
                errors++;
                $display("[TB] FAIL %s item %0d: got key=%h c=%h idx=%0d required key=%h c=%h idx=%0d",
                         tag, j, got_key[j], got_const[j], got_idx[j],
                         model_rk[NR - j], exp_const[NR - j], NR - j);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (outValid !== 1'b0 || outBusy !== 1'b0 || outDone !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got v=%b b=%b d=%b required 0 0 0",
                     outValid, outBusy, outDone);
        end
        checks++;
        if (outRoundKey !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_key: got %h required 0", outRoundKey);
        end
        checks++;
        if (outRoundConst !== 6'h0 || outRoundIdx !== 6'h0) begin
            errors++;
            $display("[TB] FAIL reset_const_idx: got c=%h idx=%0d required 0 0",
                     outRoundConst, outRoundIdx);
        end
    endtask

    task automatic test_zero_key();
        int cyc;
        do_reset();
        build_model(128'h0);
        start_op(128'h0, 1'b0, cyc);
        checks++;
        if (cyc !== NR) begin
            errors++;
            $display("[TB] FAIL zero_latency: got %0d required %0d", cyc, NR);
        end
        collect(100, 1'b0);
        compare_stream("zero_key");
        for (int j = 0; j < NR; j++) begin
            checks++;
            if (got_key[j] !== 64'h0) begin
                errors++;
                $display("[TB] FAIL zero_key_value %0d: got %h required 0", j, got_key[j]);
            end
        end
        checks++;
        if (n_done !== 1 || timed_out) begin
            errors++;
            $display("[TB] FAIL zero_done: got %0d pulses (timeout=%0b) required 1", n_done, timed_out);
        end
        @(negedge inClk);
        checks++;
        if (outDone !== 1'b0 || outBusy !== 1'b0 || outValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_after_done: got d=%b b=%b v=%b required 0 0 0",
                     outDone, outBusy, outValid);
        end
    endtask

    task automatic test_golden();
        int cyc;
        do_reset();
        build_model(GOLD_KEY);
        start_op(GOLD_KEY, 1'b0, cyc);
        collect(100, 1'b0);
        compare_stream("golden");
        checks++;
        if (got_key[NR - 1] !== 64'h040506070C0D0E0F || got_const[NR - 1] !== 6'h01 ||
            got_idx[NR - 1] !== 6'd1) begin
            errors++;
            $display("[TB] FAIL golden_last: got key=%h c=%h idx=%0d required 040506070c0d0e0f 01 1",
                     got_key[NR - 1], got_const[NR - 1], got_idx[NR - 1]);
        end
        checks++;
        if (got_key[NR - 2] !== 64'h0001020308090A0B) begin
            errors++;
            $display("[TB] FAIL golden_round2: got %h required 0001020308090a0b", got_key[NR - 2]);
        end
`ifdef GIFT_INV_KS_SELFCHECK_EN
        checks++;
        if (err_at_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL golden_selfcheck: got outErr=%b required 0", err_at_done);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int cyc;
        // Follows test_golden directly: start in the first idle cycle.
        build_model(128'h0);
        start_op(128'h0, 1'b0, cyc);
        checks++;
        if (cyc !== NR) begin
            errors++;
            $display("[TB] FAIL b2b_latency: got %0d required %0d", cyc, NR);
        end
        collect(100, 1'b0);
        compare_stream("b2b");
    endtask

    task automatic test_backpressure();
        int cyc;
        do_reset();
        build_model(GOLD_KEY);
        start_op(GOLD_KEY, 1'b0, cyc);
        collect(50, 1'b0);
        compare_stream("backpressure");
        checks++;
        if (n_unstable !== 0 || timed_out) begin
            errors++;
            $display("[TB] FAIL backpressure_stable: got %0d unstable (timeout=%0b) required 0",
                     n_unstable, timed_out);
        end
    endtask

    task automatic test_start_ignored();
        int cyc;
        logic [127:0] k;
        do_reset();
        k = 128'h0123456789ABCDEFFEDCBA9876543210;
        build_model(k);
        start_op(k, 1'b1, cyc);
        checks++;
        if (cyc !== NR) begin
            errors++;
            $display("[TB] FAIL ignore_latency: got %0d required %0d", cyc, NR);
        end
        collect(70, 1'b1);
        compare_stream("ignore_start");
        @(negedge inClk);
        checks++;
        if (outBusy !== 1'b0 || outValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ignore_final_start: got busy=%b valid=%b required 0 0",
                     outBusy, outValid);
        end
    endtask

    task automatic test_reset_mid_emit();
        int cyc;
        do_reset();
        build_model(GOLD_KEY);
        start_op(128'hFFFF_0000_1234_5678_9ABC_DEF0_1357_9BDF, 1'b0, cyc);
        inReady = 1'b1;
        repeat (5) @(negedge inClk);
        inRstN = 1'b0;
        @(negedge inClk);
        inRstN  = 1'b1;
        inReady = 1'b0;
        checks++;
        if (outValid !== 1'b0 || outBusy !== 1'b0 || outRoundIdx !== 6'd0 ||
            outRoundKey !== 64'h0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got v=%b b=%b idx=%0d key=%h required 0 0 0 0",
                     outValid, outBusy, outRoundIdx, outRoundKey);
        end
        start_op(GOLD_KEY, 1'b0, cyc);
        checks++;
        if (cyc !== NR) begin
            errors++;
            $display("[TB] FAIL mid_reset_restart: got latency %0d required %0d", cyc, NR);
        end
        collect(100, 1'b0);
        compare_stream("mid_reset");
    endtask

    initial begin
        inRstN  = 1'b0;
        inStart = 1'b0;
        inReady = 1'b0;
        inKey   = '0;
        test_reset();
        test_zero_key();
        test_golden();
        test_back_to_back();
        test_backpressure();
        test_start_ignored();
        test_reset_mid_emit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
